lfsr9_source: RTL and testbench

- Upstream pseudo-random stage for the 9-bit carry adder. Its `rand_out` drives the adder B operand, and user switches drive A, so the adder carry forms the random compare result.
- Contains a 9-bit Fibonacci LFSR with period 511, a programmable step-rate divider, seed loading and lockup recovery.
- Emits a one-cycle `rand_valid` strobe each time a new value is presented, so the downstream consumer samples the carry exactly once per value.

---
 rtl/lfsr9_source.sv | 117 +++++++++++
 tb/tb_lfsr9_source.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr9_source.sv
// lfsr9_source: pseudo-random operand source for the 9-bit carry adder.
// A 9-bit Fibonacci LFSR (x^9 + x^5 + 1, period 511) advanced once every
// DIV enabled clock cycles, with seed loading and all-zero lockup recovery.
//
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : high = divider counts and LFSR steps; low = hold
//   seed_load  : synchronous seed load (pulse or level), beats enable
//   seed       : seed value (zero maps to SEED_DEFAULT)
//   rand_out   : current LFSR state, registered
//   rand_valid : one-cycle strobe with each newly stepped value
//   wrap       : (LFSR_WRAP_FLAG_EN only) pulses with rand_valid on the
//                511th step since reset / seed load
//
// Optional feature macro: LFSR_WRAP_FLAG_EN
module lfsr9_source #(
  parameter int unsigned DIV          = 50,
  parameter logic [8:0]  SEED_DEFAULT = 9'h001
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       seed_load,
  input  logic [8:0] seed,
  output logic [8:0] rand_out,
  output logic       rand_valid
`ifdef LFSR_WRAP_FLAG_EN
  ,
  output logic       wrap
`endif
);

  localparam int unsigned       SW      = 9;
  localparam int unsigned       CW      = $clog2(DIV + 1);
  localparam logic [CW-1:0]     TERM    = CW'(DIV - 1);
  localparam logic [SW-1:0]     WRAP_AT = SW'(510);

  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          step_c;

  // Next-state: seed load > lockup recovery > divider/step.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    valid_d = 1'b0;
    step_c  = 1'b0;
    if (seed_load) begin
      state_d = (seed == '0) ? SEED_DEFAULT : seed;
      count_d = '0;
    end else if (state_q == '0) begin
      state_d = SEED_DEFAULT;
      count_d = '0;
    end else if (enable) begin
      if (count_q == TERM) begin
        count_d = '0;
        state_d = {state_q[SW-2:0], state_q[8] ^ state_q[4]};
        valid_d = 1'b1;
        step_c  = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEED_DEFAULT;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign rand_out   = state_q;
  assign rand_valid = valid_q;

`ifdef LFSR_WRAP_FLAG_EN
  logic [SW-1:0] steps_q, steps_d;
  logic          wrap_q, wrap_d;

  // Step counter: flags the step that brings the state back to its start.
  always_comb begin
    steps_d = steps_q;
    wrap_d  = 1'b0;
    if (seed_load) begin
      steps_d = '0;
    end else if (step_c) begin
      if (steps_q == WRAP_AT) begin
        steps_d = '0;
        wrap_d  = 1'b1;
      end else begin
        steps_d = steps_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      steps_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      steps_q <= steps_d;
      wrap_q  <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_lfsr9_source.sv
// Bench for lfsr9_source: instance A runs DIV=1, instance B runs DIV=4.
// A reference model pushes expected outputs per cycle; tests pop and compare.
module tb_lfsr9_source;

  localparam int unsigned DIV_A = 1;
  localparam int unsigned DIV_B = 4;
  localparam logic [8:0]  SEED  = 9'h001;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en_a, sl_a, rv_a;
  logic [8:0] sd_a, ro_a;
  logic       en_b, sl_b, rv_b;
  logic [8:0] sd_b, ro_b;
`ifdef LFSR_WRAP_FLAG_EN
  logic       wr_a, wr_b;
`endif

  always #5 clk = ~clk;

  lfsr9_source #(.DIV(DIV_A), .SEED_DEFAULT(SEED)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .seed_load(sl_a), .seed(sd_a),
    .rand_out(ro_a), .rand_valid(rv_a)
`ifdef LFSR_WRAP_FLAG_EN
    , .wrap(wr_a)
`endif
  );

  lfsr9_source #(.DIV(DIV_B), .SEED_DEFAULT(SEED)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .seed_load(sl_b), .seed(sd_b),
    .rand_out(ro_b), .rand_valid(rv_b)
`ifdef LFSR_WRAP_FLAG_EN
    , .wrap(wr_b)
`endif
  );

  typedef struct packed {
    logic [8:0] ro;
    logic       rv;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [8:0]  ms_a, ms_b;
  int unsigned mc_a, mc_b;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [8:0] lfsr_next(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  // Behavioural reference for one clock edge.
  task automatic model_step(input int unsigned div, input logic en, input logic sl,
                            input logic [8:0] sd, inout logic [8:0] st,
                            inout int unsigned cnt, output logic v);
    v = 1'b0;
    if (sl) begin
      st  = (sd == 9'h000) ? SEED : sd;
      cnt = 0;
    end else if (st == 9'h000) begin
      st  = SEED;
      cnt = 0;
    end else if (en) begin
      if (cnt == div - 1) begin
        cnt = 0;
        st  = lfsr_next(st);
        v   = 1'b1;
      end else begin
        cnt = cnt + 1;
      end
    end
  endtask

  task automatic model_reset();
    ms_a = SEED; ms_b = SEED;
    mc_a = 0;    mc_b = 0;
    q_a.delete(); q_b.delete();
  endtask

  // Predict this edge for both instances, then advance to 1 ns after it.
  task automatic tick();
    logic v;
    model_step(DIV_A, en_a, sl_a, sd_a, ms_a, mc_a, v);
    q_a.push_back({ms_a, v});
    model_step(DIV_B, en_b, sl_b, sd_b, ms_b, mc_b, v);
    q_b.push_back({ms_b, v});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en_a = 1'b0; sl_a = 1'b0; sd_a = '0;
    en_b = 1'b0; sl_b = 1'b0; sd_b = '0;
    #12;
    n_cmp++; if (ro_a !== 9'h001) begin n_err++; $display("FAIL reset_ro_a: got %h want 001", ro_a); end
    n_cmp++; if (rv_a !== 1'b0)   begin n_err++; $display("FAIL reset_rv_a: got %b want 0", rv_a); end
    n_cmp++; if (ro_b !== 9'h001) begin n_err++; $display("FAIL reset_ro_b: got %h want 001", ro_b); end
    n_cmp++; if (rv_b !== 1'b0)   begin n_err++; $display("FAIL reset_rv_b: got %b want 0", rv_b); end
`ifdef LFSR_WRAP_FLAG_EN
    n_cmp++; if (wr_a !== 1'b0)   begin n_err++; $display("FAIL reset_wrap: got %b want 0", wr_a); end
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    tick();
    q_a.delete(); q_b.delete();
    n_cmp++; if (ro_a !== 9'h001 || rv_a !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: got %h/%b want 001/0", ro_a, rv_a);
    end
  endtask

  task automatic test_div1_seq();
    logic [8:0] tbl [5];
    exp_t e;
    tbl = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h021};
    en_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = q_a.pop_front();
      n_cmp++; if (ro_a !== tbl[i] || rv_a !== 1'b1) begin
        n_err++; $display("FAIL div1_seq[%0d]: got %h/%b want %h/1", i, ro_a, rv_a, tbl[i]);
      end
      n_cmp++; if ({ro_a, rv_a} !== {e.ro, e.rv}) begin
        n_err++; $display("FAIL div1_sb[%0d]: got %h/%b want %h/%b", i, ro_a, rv_a, e.ro, e.rv);
      end
    end
    en_a = 1'b0;
    q_b.delete();
  endtask

  task automatic test_divider();
    exp_t e;
    int   pulses[$];
    int   first;
    en_b = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      e = q_b.pop_front();
      if (rv_b === 1'b1) pulses.push_back(i);
      n_cmp++; if ({ro_b, rv_b} !== {e.ro, e.rv}) begin
        n_err++; $display("FAIL div4_sb[%0d]: got %h/%b want %h/%b", i, ro_b, rv_b, e.ro, e.rv);
      end
    end
    n_cmp++; if (pulses.size() != 3 || pulses[0] != 4 || pulses[1] != 8 || pulses[2] != 12) begin
      n_err++; $display("FAIL div4_pulses: got count %0d want 3 at 4,8,12", pulses.size());
    end
    // Two counts, hold five cycles, resume: pulse lands on relative cycle 9.
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      en_b = (i <= 2 || i > 7);
      tick();
      e = q_b.pop_front();
      if (rv_b === 1'b1 && first == 0) first = i;
      n_cmp++; if ({ro_b, rv_b} !== {e.ro, e.rv}) begin
        n_err++; $display("FAIL hold_sb[%0d]: got %h/%b want %h/%b", i, ro_b, rv_b, e.ro, e.rv);
      end
    end
    n_cmp++; if (first != 9) begin
      n_err++; $display("FAIL hold_delay: pulse at %0d want 9", first);
    end
    en_b = 1'b0;
    q_a.delete();
  endtask

  task automatic test_seed();
    exp_t e;
    en_a = 1'b1; sl_a = 1'b1; sd_a = 9'h1FF;
    tick(); e = q_a.pop_front();
    n_cmp++; if (ro_a !== 9'h1FF || rv_a !== 1'b0 || e.ro !== 9'h1FF) begin
      n_err++; $display("FAIL seed_1ff: got %h/%b want 1ff/0", ro_a, rv_a);
    end
    sl_a = 1'b0;
    tick(); e = q_a.pop_front();
    n_cmp++; if (ro_a !== 9'h1FE || rv_a !== 1'b1 || e.ro !== 9'h1FE) begin
      n_err++; $display("FAIL seed_step: got %h/%b want 1fe/1", ro_a, rv_a);
    end
    sl_a = 1'b1; sd_a = 9'h000;
    tick(); e = q_a.pop_front();
    n_cmp++; if (ro_a !== 9'h001 || rv_a !== 1'b0) begin
      n_err++; $display("FAIL seed_zero: got %h/%b want 001/0", ro_a, rv_a);
    end
    sd_a = 9'h0AB;
    for (int i = 0; i < 3; i++) begin
      tick(); e = q_a.pop_front();
      n_cmp++; if ({ro_a, rv_a} !== {e.ro, e.rv} || ro_a !== 9'h0AB) begin
        n_err++; $display("FAIL seed_level[%0d]: got %h/%b want 0ab/0", i, ro_a, rv_a);
      end
    end
    sl_a = 1'b0; en_a = 1'b0;
    q_b.delete();
  endtask

  task automatic test_seed_vs_terminal();
    exp_t e;
    int   gap;
    bit   seen;
    en_b = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(); void'(q_b.pop_front());
      seen = (rv_b === 1'b1);
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL svt_sync: got no pulse want pulse within 10"); end
    for (int i = 0; i < 3; i++) begin tick(); void'(q_b.pop_front()); end
    sl_b = 1'b1; sd_b = 9'h055;
    tick(); e = q_b.pop_front();
    n_cmp++; if (ro_b !== 9'h055 || rv_b !== 1'b0 || e.rv !== 1'b0) begin
      n_err++; $display("FAIL svt_load: got %h/%b want 055/0", ro_b, rv_b);
    end
    sl_b = 1'b0;
    gap = 0;
    for (int i = 1; i <= 12 && gap == 0; i++) begin
      tick(); e = q_b.pop_front();
      if (rv_b === 1'b1) gap = i;
      n_cmp++; if ({ro_b, rv_b} !== {e.ro, e.rv}) begin
        n_err++; $display("FAIL svt_sb[%0d]: got %h/%b want %h/%b", i, ro_b, rv_b, e.ro, e.rv);
      end
    end
    n_cmp++; if (gap != 4) begin n_err++; $display("FAIL svt_gap: got %0d want 4", gap); end
    en_b = 1'b0;
    q_a.delete();
  endtask

  task automatic test_async_reset();
    exp_t e;
    en_a = 1'b1; en_b = 1'b1;
    tick(); tick();
    e = q_a.pop_front(); e = q_a.pop_front();
    n_cmp++; if (rv_a !== 1'b1 || ro_a !== e.ro) begin
      n_err++; $display("FAIL pre_reset: got %h/%b want %h/1", ro_a, rv_a, e.ro);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (ro_a !== 9'h001 || rv_a !== 1'b0) begin
      n_err++; $display("FAIL async_a: got %h/%b want 001/0", ro_a, rv_a);
    end
    n_cmp++; if (ro_b !== 9'h001 || rv_b !== 1'b0) begin
      n_err++; $display("FAIL async_b: got %h/%b want 001/0", ro_b, rv_b);
    end
    en_a = 1'b0; en_b = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

`ifdef LFSR_WRAP_FLAG_EN
  task automatic test_wrap();
    exp_t e;
    bit   seen [512];
    int   dup, wraps;
    dup = 0; wraps = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    en_a = 1'b1; en_b = 1'b0;
    for (int i = 1; i <= 511; i++) begin
      tick(); e = q_a.pop_front(); void'(q_b.pop_front());
      if (seen[ro_a] || ro_a == 9'h000) dup++;
      seen[ro_a] = 1'b1;
      if (wr_a === 1'b1) wraps++;
      n_cmp++; if (wr_a !== (i == 511)) begin
        n_err++; $display("FAIL wrap[%0d]: got %b want %b", i, wr_a, (i == 511));
      end
      n_cmp++; if ({ro_a, rv_a} !== {e.ro, e.rv}) begin
        n_err++; $display("FAIL wrap_sb[%0d]: got %h/%b want %h/%b", i, ro_a, rv_a, e.ro, e.rv);
      end
    end
    n_cmp++; if (ro_a !== 9'h001) begin n_err++; $display("FAIL wrap_end: got %h want 001", ro_a); end
    n_cmp++; if (dup != 0 || wraps != 1) begin
      n_err++; $display("FAIL wrap_distinct: got dup %0d wraps %0d want 0/1", dup, wraps);
    end
    tick();
    n_cmp++; if (wr_a !== 1'b0) begin n_err++; $display("FAIL wrap_after: got %b want 0", wr_a); end
    en_a = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_div1_seq();
    test_divider();
    test_seed();
    test_seed_vs_terminal();
    test_async_reset();
`ifdef LFSR_WRAP_FLAG_EN
    test_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
